// File: rtl/control_unit.sv
// Instruction decoder and IDLE/RUN/HALT sequencer for the single-cycle RV64 core.
// Controls are combinational from state and Instruction; halted, cause and instret are registered.
module control_unit #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     Instruction,
  input  logic            halt_clr,
  output logic [1:0]      ALUControl,
  output logic            RegWrite,
  output logic            MemWrite,
  output logic            Branch,
  output logic            MemToReg,
  output logic            ALUScr,
  output logic [BITS-1:0] Imm,
  output logic            halted,
  output logic [1:0]      cause,
  output logic [BITS-1:0] instret,
  output logic [1:0]      state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_SYS  = 2'b01;
  localparam logic [1:0] CAUSE_ILL  = 2'b10;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic        dec_rw, dec_mw, dec_br, dec_mtr, dec_src;
  logic        is_sys, is_ill, run_active;
  logic [1:0]  state_next;
  logic        unused_rs1;

  assign opcode     = Instruction[6:0];
  assign funct3     = Instruction[14:12];
  assign funct7     = Instruction[31:25];
  assign unused_rs1 = ^Instruction[19:15];

  always_comb begin
    ALUControl = 2'b00;
    dec_rw     = 1'b0;
    dec_mw     = 1'b0;
    dec_br     = 1'b0;
    dec_mtr    = 1'b0;
    dec_src    = 1'b0;
    imm12      = 12'd0;
    is_sys     = 1'b0;
    is_ill     = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_rw = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      ALUControl = 2'b00;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) ALUControl = 2'b01;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000) ALUControl = 2'b10;
        else if (funct3 == 3'b110 && funct7 == 7'b0000000) ALUControl = 2'b11;
        else is_ill = 1'b1;
      end
      7'b0010011: begin
        dec_rw  = 1'b1;
        dec_src = 1'b1;
        imm12   = Instruction[31:20];
        case (funct3)
          3'b000:  ALUControl = 2'b00;
          3'b111:  ALUControl = 2'b10;
          3'b110:  ALUControl = 2'b11;
          default: is_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_rw  = 1'b1;
        dec_mtr = 1'b1;
        dec_src = 1'b1;
        imm12   = Instruction[31:20];
        is_ill  = (funct3 != 3'b011);
      end
      7'b0100011: begin
        dec_mw  = 1'b1;
        dec_src = 1'b1;
        imm12   = {Instruction[31:25], Instruction[11:7]};
        is_ill  = (funct3 != 3'b011);
      end
      7'b1100011: begin
        // Branch offset is kept halved; the datapath shifter scales it.
        dec_br     = 1'b1;
        ALUControl = 2'b01;
        imm12      = {Instruction[31], Instruction[7], Instruction[30:25], Instruction[11:8]};
        is_ill     = (funct3 != 3'b000);
      end
      7'b1110011: is_sys = 1'b1;
      default:    is_ill = 1'b1;
    endcase
    if (is_sys || is_ill) imm12 = 12'd0;
  end

  assign Imm        = {{(BITS-12){imm12[11]}}, imm12};
  assign run_active = (state == RUN) && !is_sys && !is_ill;

  assign RegWrite = run_active & dec_rw;
  assign MemWrite = run_active & dec_mw;
  assign Branch   = run_active & dec_br;
  assign MemToReg = run_active & dec_mtr;
  assign ALUScr   = run_active & dec_src;
  assign halted   = (state == HALT);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (is_sys || is_ill) state_next = HALT;
      HALT:    if (halt_clr) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cause   <= CAUSE_NONE;
      instret <= '0;
    end else begin
      state <= state_next;
      if (run_active) instret <= instret + BITS'(1);
      if (state == RUN && is_sys)        cause <= CAUSE_SYS;
      else if (state == RUN && is_ill)   cause <= CAUSE_ILL;
      else if (state == HALT && halt_clr) cause <= CAUSE_NONE;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, decode table, system/illegal halt and clear, async reset.
module tb_control_unit;
  localparam int BITS = 64;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_ANDI = 32'h0FF07093;
  localparam logic [31:0] I_LD   = 32'hFF813283;
  localparam logic [31:0] I_SD   = 32'h00513823;
  localparam logic [31:0] I_BEQ  = 32'hFE208EE3;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;
  localparam logic [31:0] I_LW   = 32'hFF812283;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     instr = '0;
  logic            halt_clr = 1'b0;
  logic [1:0]      alu;
  logic            reg_write, mem_write, branch, mem_to_reg, alu_src;
  logic [BITS-1:0] imm;
  logic            halted;
  logic [1:0]      cause;
  logic [BITS-1:0] instret;
  logic [1:0]      state;
  logic [4:0]      ctl;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] exp_instret = '0;

  assign ctl = {reg_write, mem_write, branch, mem_to_reg, alu_src};

  control_unit #(.BITS(BITS)) dut (
    .clk(clk), .rst(rst), .Instruction(instr), .halt_clr(halt_clr),
    .ALUControl(alu), .RegWrite(reg_write), .MemWrite(mem_write), .Branch(branch),
    .MemToReg(mem_to_reg), .ALUScr(alu_src), .Imm(imm), .halted(halted),
    .cause(cause), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; instr = I_ADD; halt_clr = 1'b0;
    #2;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b expected 00000", ctl); end
    checks++; if (instret !== '0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if (halted !== 1'b0 || cause !== 2'b00) begin errors++; $display("FAIL reset_halt: got halted=%b cause=%b expected 0/00", halted, cause); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL idle_cycle_ctl: got %b expected 00000", ctl); end
    tick();
    checks++; if (ctl !== 5'b10000 || alu !== 2'b00) begin errors++; $display("FAIL first_run_add: got ctl=%b alu=%b expected 10000/00", ctl, alu); end
    checks++; if (instret !== '0) begin errors++; $display("FAIL instret_after_idle: got %0d expected 0", instret); end
    tick();
    exp_instret = 1;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL instret_first: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_decode;
    logic [31:0]     v_instr [9];
    logic [4:0]      v_ctl   [9];
    logic [1:0]      v_alu   [9];
    logic [BITS-1:0] v_imm   [9];
    v_instr = '{I_ADD, I_SUB, I_AND, I_OR, I_ADDI, I_ANDI, I_LD, I_SD, I_BEQ};
    v_ctl   = '{5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b10001, 5'b10011, 5'b01001, 5'b00100};
    v_alu   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    v_imm   = '{64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h00000000000000FF,
                64'hFFFFFFFFFFFFFFF8, 64'h0000000000000010, 64'hFFFFFFFFFFFFFFFE};
    for (int i = 0; i < 9; i++) begin
      instr = v_instr[i];
      #1;
      checks++; if (ctl !== v_ctl[i]) begin errors++; $display("FAIL decode_ctl[%0d]: got %b expected %b", i, ctl, v_ctl[i]); end
      checks++; if (alu !== v_alu[i]) begin errors++; $display("FAIL decode_alu[%0d]: got %b expected %b", i, alu, v_alu[i]); end
      checks++; if (imm !== v_imm[i]) begin errors++; $display("FAIL decode_imm[%0d]: got %h expected %h", i, imm, v_imm[i]); end
      tick();
      exp_instret++;
    end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL decode_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_ecall;
    instr = I_ECALL;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL ecall_gated: got %b expected 00000", ctl); end
    checks++; if (imm !== '0) begin errors++; $display("FAIL ecall_imm: got %h expected 0", imm); end
    tick();
    checks++; if (halted !== 1'b1 || cause !== 2'b01) begin errors++; $display("FAIL ecall_halt: got halted=%b cause=%b expected 1/01", halted, cause); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL ecall_instret: got %0d expected %0d", instret, exp_instret); end
    instr = I_ADD;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL halt_gated: got %b expected 00000", ctl); end
    tick();
    checks++; if (halted !== 1'b1 || instret !== exp_instret) begin errors++; $display("FAIL halt_hold: got halted=%b instret=%0d expected 1/%0d", halted, instret, exp_instret); end
    halt_clr = 1'b1;
    tick();
    halt_clr = 1'b0;
    checks++; if (halted !== 1'b0 || cause !== 2'b00 || state !== S_RUN) begin errors++; $display("FAIL ecall_clear: got halted=%b cause=%b state=%0d expected 0/00/1", halted, cause, state); end
    checks++; if (ctl !== 5'b10000) begin errors++; $display("FAIL resume_ctl: got %b expected 10000", ctl); end
    tick();
    exp_instret++;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL resume_instret: got %0d expected %0d", instret, exp_instret); end
  endtask

  task automatic test_illegal;
    instr = I_ILL; halt_clr = 1'b1;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL illegal_gated: got %b expected 00000", ctl); end
    tick();
    halt_clr = 1'b0;
    checks++; if (halted !== 1'b1 || cause !== 2'b10) begin errors++; $display("FAIL illegal_halt_with_clr: got halted=%b cause=%b expected 1/10", halted, cause); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL illegal_instret: got %0d expected %0d", instret, exp_instret); end
    instr = I_ADD; halt_clr = 1'b1;
    tick();
    halt_clr = 1'b0;
    checks++; if (halted !== 1'b0 || cause !== 2'b00) begin errors++; $display("FAIL illegal_clear: got halted=%b cause=%b expected 0/00", halted, cause); end
    instr = I_LW;
    #1;
    checks++; if (ctl !== 5'b0) begin errors++; $display("FAIL bad_funct3_gated: got %b expected 00000", ctl); end
    tick();
    checks++; if (halted !== 1'b1 || cause !== 2'b10) begin errors++; $display("FAIL bad_funct3_halt: got halted=%b cause=%b expected 1/10", halted, cause); end
    instr = I_ADD; halt_clr = 1'b1;
    tick();
    halt_clr = 1'b0;
  endtask

  task automatic test_async_reset;
    instr = I_ADD;
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    exp_instret = 5;
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL pre_reset_instret: got %0d expected %0d", instret, exp_instret); end
    #2 rst = 1'b0;
    #1;
    checks++; if (instret !== '0 || ctl !== 5'b0) begin errors++; $display("FAIL async_reset: got instret=%0d ctl=%b expected 0/00000", instret, ctl); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ctl !== 5'b0 || state !== S_IDLE) begin errors++; $display("FAIL post_reset_idle: got ctl=%b state=%0d expected 00000/0", ctl, state); end
    tick();
    checks++; if (ctl !== 5'b10000 || instret !== '0) begin errors++; $display("FAIL post_reset_run: got ctl=%b instret=%0d expected 10000/0", ctl, instret); end
    tick();
    checks++; if (instret !== 64'd1) begin errors++; $display("FAIL post_reset_count: got %0d expected 1", instret); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_ecall();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder and run/halt sequencer for the single-cycle RV64 core. It consumes the 32-bit `Instruction` word that the datapath fetches from instruction memory. It produces every datapath control input in the same cycle: `ALUControl`, `RegWrite`, `MemWrite`, `Branch`, `MemToReg`, `ALUScr` and `Imm`. A small FSM suppresses architectural writes for one cycle after reset, then stops the core on a system or illegal instruction. The block also keeps a retired-instruction counter and a halt cause.

## Interface
- `BITS`, 64, datapath word width; sets the widths of `Imm` and `instret`.
- `clk`  in  1  rising-edge clock, shared with the datapath.
- `rst`  in  1  reset; asynchronous, active-low (0 = in reset).
- `Instruction`  in  32  current instruction from instruction memory.
- `halt_clr`  in  1  leaves HALT and clears `cause`.
- `ALUControl`  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- `RegWrite`, `MemWrite`, `Branch`, `MemToReg`, `ALUScr`  out  1 each  datapath controls.
- `Imm`  out  BITS  sign-extended immediate.
- `halted`  out  1  high while the FSM is in HALT.
- `cause`  out  2  halt cause: 00 none, 01 ecall/ebreak, 10 illegal.
- `instret`  out  BITS  count of retired instructions.

## Operation
- FSM states: IDLE, RUN, HALT. Reset forces IDLE.
  - IDLE → RUN unconditionally on the next edge.
  - RUN → HALT on the edge that ends a cycle presenting a system or illegal instruction.
  - HALT → RUN on any edge with `halt_clr`=1.
- Decoding is combinational from `Instruction`. Supported opcodes:
  - 0110011: add (funct3 000, funct7 0000000, ALU 00), sub (funct3 000, funct7 0100000, ALU 01), and (funct3 111, ALU 10), or (funct3 110, ALU 11). RegWrite=1, ALUScr=0.
  - 0010011: addi (funct3 000), andi (111), ori (110). RegWrite=1, ALUScr=1, Imm = sext(Instruction[31:20]).
  - 0000011 with funct3 011 (ld): RegWrite=1, ALUScr=1, MemToReg=1, ALU 00, Imm = sext(Instruction[31:20]).
  - 0100011 with funct3 011 (sd): MemWrite=1, ALUScr=1, ALU 00, Imm = sext({Instruction[31:25], Instruction[11:7]}).
  - 1100011 with funct3 000 (beq): Branch=1, ALU 01, ALUScr=0.
    - Imm = sext({Instruction[31], Instruction[7], Instruction[30:25], Instruction[11:8]}), i.e. offset/2.
    - The datapath shifter applies the scaling.
  - 1110011: system. Cause 01.
  - Any other opcode, funct3 or funct7 combination is illegal. Cause 10.
- Gating: all five 1-bit controls are 0 in these cases:
  - state IDLE;
  - state HALT;
  - a system or illegal instruction in RUN.
  - `ALUControl` and `Imm` still follow the decode; they are don't-care when gated.
- For system, illegal and R-type instructions, Imm = 0.
- `instret` increments by 1 on every edge in RUN where the instruction is legal and not system. It wraps from 2^BITS−1 to 0.
- `cause` is written on the RUN→HALT edge. It is cleared to 00 on the HALT→RUN edge.
- `halt_clr` is ignored outside HALT.

## Timing
- Reset values: state IDLE, `halted`=0, `cause`=00, `instret`=0, all 1-bit controls 0.
- Controls have zero latency: they are valid in the same cycle `Instruction` is valid.
- Exactly one cycle after `rst` deasserts is gated (IDLE). The first RUN cycle follows.
- The halting instruction is itself suppressed. `halted` rises on the following edge.
- Halting instruction and `halt_clr` in the same cycle: the FSM enters HALT. `halt_clr` only acts in HALT.
- Reset mid-operation takes effect immediately and asynchronously:
  - controls drop to 0 without waiting for a clock edge;
  - `instret` and `cause` clear;
  - the next cycle out of reset is IDLE again.
- `halted` and `cause` are registered outputs. The five controls, `ALUControl` and `Imm` are combinational from state and `Instruction`.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3) held: cycle 0 after release has all controls 0. Cycle 1 has RegWrite=1, ALUControl=00, ALUScr=0. `instret` reads 1 after that edge.
- `ld x5,-8(x2)` (0xFF813283): RegWrite=1, MemToReg=1, ALUScr=1, Imm=0xFFFFFFFFFFFFFFF8. `sd x5,16(x2)` (0x00513823): MemWrite=1, RegWrite=0, Imm=0x10.
- `beq x1,x2,-4` (0xFE208EE3): Branch=1, ALUControl=01, Imm=0xFFFFFFFFFFFFFFFE.
- `ecall` (0x00000073) in RUN: that cycle's controls are all 0. Next edge gives `halted`=1, `cause`=01, `instret` unchanged. Later instructions stay gated. Pulsing `halt_clr` gives RUN with `cause`=00.
- Illegal word 0xFFFFFFFF: same sequence as `ecall` but with `cause`=10. With `halt_clr` and the illegal word in the same RUN cycle, the block still halts.
- Drive `rst`=0 asynchronously mid-RUN with `instret`=5: `instret`=0 and controls drop to 0 immediately. After release there is one IDLE cycle, then decoding resumes.
